// File: rtl/bit_set_sequencer.sv
// Builds an N-bit mask from a base value by OR-ing in one bit per accepted index.
// Define BITSEQ_ERR_SKIP_EN to skip and count bad indices instead of entering ERR.
module bit_set_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [N-1:0]     i_base,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_idx_valid,
  input  logic [N-1:0]     i_idx,
  output logic             o_idx_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [N-1:0]     o_out,
  output logic             o_ERR,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int SH_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]        state;
  logic [N-1:0]      acc;
  logic [CNT_W-1:0]  remaining;
  logic signed [N-1:0] idx_s;
  logic              idx_hs;
  logic              last_idx;

  // Negative indices and indices past the top bit are both rejected.
  function automatic logic idx_bad(input logic signed [N-1:0] idx);
    return idx[N-1] || (32'($unsigned(idx)) >= 32'(N));
  endfunction

  function automatic logic [N-1:0] bit_set(input logic [N-1:0] a,
                                           input logic signed [N-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return a | (one << idx[SH_W-1:0]);
  endfunction

  assign idx_s    = $signed(i_idx);
  assign idx_hs   = (state == S_RUN) && i_idx_valid;
  assign last_idx = (remaining == CNT_W'(1));

`ifdef BITSEQ_ERR_SKIP_EN
  logic [CNT_W-1:0] err_cnt;
  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      acc       <= '0;
      remaining <= '0;
`ifdef BITSEQ_ERR_SKIP_EN
      err_cnt   <= '0;
`endif
    end else begin
      case (state)
        // A start from ERR is identical to one from IDLE.
        S_IDLE, S_ERR: begin
          if (i_start) begin
            acc       <= i_base;
            remaining <= i_cnt;
`ifdef BITSEQ_ERR_SKIP_EN
            err_cnt   <= '0;
`endif
            state     <= (i_cnt == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (idx_hs) begin
            if (!idx_bad(idx_s)) begin
              acc       <= bit_set(acc, idx_s);
              remaining <= remaining - CNT_W'(1);
              if (last_idx) state <= S_DONE;
            end else begin
`ifdef BITSEQ_ERR_SKIP_EN
              remaining <= remaining - CNT_W'(1);
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
              if (last_idx) state <= S_DONE;
`else
              acc       <= '0;
              remaining <= '0;
              state     <= S_ERR;
`endif
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // acc is already cleared on entry to ERR, so it can drive o_out directly.
  assign o_out       = acc;
  assign o_idx_ready = (state == S_RUN);
  assign o_busy      = (state == S_RUN);
  assign o_done      = (state == S_DONE);
  assign o_ERR       = (state == S_ERR);

endmodule

// File: tb/tb_bit_set_sequencer.sv
// Directed bench for bit_set_sequencer (N=8, CNT_W=4); the skip-mode case runs
// only when BITSEQ_ERR_SKIP_EN is defined.
module tb_bit_set_sequencer;
  localparam int N     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [N-1:0]     base;
  logic [CNT_W-1:0] cnt;
  logic             idx_valid;
  logic [N-1:0]     idx;
  logic             idx_ready;
  logic             busy;
  logic             done;
  logic [N-1:0]     out;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  bit_set_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .i_base      (base),
    .i_cnt       (cnt),
    .i_idx_valid (idx_valid),
    .i_idx       (idx),
    .o_idx_ready (idx_ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_out       (out),
    .o_ERR       (err),
    .o_err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [N-1:0] b, input logic [CNT_W-1:0] c);
    start = 1'b1; base = b; cnt = c;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; base = '0; cnt = '0; idx_valid = 1'b0; idx = '0;
    tick(); tick();
    check("rst_out",   32'(out),       32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_done",  32'(done),      32'h0);
    check("rst_err",   32'(err),       32'h0);
    check("rst_ready", 32'(idx_ready), 32'h0);
    check("rst_ecnt",  32'(err_cnt),   32'h0);
    rstn = 1'b1;
    tick();
    check("idle_ready", 32'(idx_ready), 32'h0);

    // Normal run: 0,3,7 back-to-back
    do_start(8'h00, 4'd3);
    check("run_busy",  32'(busy),      32'h1);
    check("run_ready", 32'(idx_ready), 32'h1);
    idx_valid = 1'b1; idx = 8'd0; tick();
    check("run_done0", 32'(done), 32'h0);
    idx = 8'd3; tick();
    check("run_done1", 32'(done), 32'h0);
    idx = 8'd7; tick();
    idx_valid = 1'b0;
    check("run_done",  32'(done), 32'h1);
    check("run_out",   32'(out),  32'h89);
    check("run_busy2", 32'(busy), 32'h0);
    tick();
    check("run_pulse", 32'(done), 32'h0);
    check("run_hold",  32'(out),  32'h89);

    // Base with stalls and an ignored mid-run start
    do_start(8'h10, 4'd2);
    idx_valid = 1'b1; idx = 8'd1; tick();
    idx_valid = 1'b0; start = 1'b1; base = 8'hFF; cnt = 4'd0; tick();
    start = 1'b0;
    check("stall_busy",  32'(busy), 32'h1);
    check("stall_out",   32'(out),  32'h12);
    tick();
    check("stall_busy2", 32'(busy), 32'h1);
    check("stall_done",  32'(done), 32'h0);
    idx_valid = 1'b1; idx = 8'd4; tick();
    idx_valid = 1'b0;
    check("stall_fin",   32'(done), 32'h1);
    check("stall_res",   32'(out),  32'h12);
    tick();
    check("stall_idle",  32'(busy), 32'h0);

    // Zero count
    do_start(8'hA5, 4'd0);
    check("zero_done",  32'(done),      32'h1);
    check("zero_ready", 32'(idx_ready), 32'h0);
    check("zero_out",   32'(out),       32'hA5);
    tick();
    check("zero_pulse", 32'(done), 32'h0);

`ifdef BITSEQ_ERR_SKIP_EN
    // Skip mode: bad indices counted, sequence completes
    do_start(8'h00, 4'd4);
    idx_valid = 1'b1;
    idx = 8'd1;  tick();
    idx = 8'd8;  tick();
    check("skip_err1", 32'(err), 32'h0);
    idx = 8'hFE; tick();
    idx = 8'd6;  tick();
    idx_valid = 1'b0;
    check("skip_done", 32'(done),    32'h1);
    check("skip_out",  32'(out),     32'h42);
    check("skip_ecnt", 32'(err_cnt), 32'h2);
    check("skip_err",  32'(err),     32'h0);
    tick();
`else
    // Error mode: negative index aborts into ERR
    do_start(8'h00, 4'd3);
    idx_valid = 1'b1;
    idx = 8'd2;  tick();
    idx = 8'hFF; tick();
    check("err_state", 32'(err),       32'h1);
    check("err_out",   32'(out),       32'h0);
    check("err_ready", 32'(idx_ready), 32'h0);
    check("err_done",  32'(done),      32'h0);
    idx = 8'd8; tick();
    idx_valid = 1'b0;
    check("err_hold",  32'(err), 32'h1);
    do_start(8'h01, 4'd1);
    check("err_clr",   32'(err), 32'h0);
    idx_valid = 1'b1; idx = 8'd1; tick();
    idx_valid = 1'b0;
    check("err_rdone", 32'(done),    32'h1);
    check("err_rout",  32'(out),     32'h03);
    check("err_ecnt",  32'(err_cnt), 32'h0);
    tick();
`endif

    // Asynchronous reset in the middle of a run
    do_start(8'h00, 4'd3);
    idx_valid = 1'b1; idx = 8'd0; tick();
    idx_valid = 1'b0;
    check("mid_out", 32'(out), 32'h01);
    #2 rstn = 1'b0;
    #1;
    check("arst_out",   32'(out),       32'h0);
    check("arst_busy",  32'(busy),      32'h0);
    check("arst_ready", 32'(idx_ready), 32'h0);
    check("arst_done",  32'(done),      32'h0);
    tick();
    rstn = 1'b1;
    tick();
    do_start(8'h00, 4'd1);
    idx_valid = 1'b1; idx = 8'd5; tick();
    idx_valid = 1'b0;
    check("post_done", 32'(done), 32'h1);
    check("post_out",  32'(out),  32'h20);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
